// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions: opcode values, the canonical NOP and fetch FSM states.
package riscv_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; push visible at head the cycle after the write (no bypass).
// No internal backpressure: the caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_q];
    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order imem requests, buffered words presented one cycle after return.
// Issues only while in-flight plus buffered words fit the buffer; redirect flushes wrong-path work.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int FW = 32 + XLEN;

    fetch_state_t    state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   in_flight_q, in_flight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            accept, push, pop;
    logic [XLEN-1:0] target_pc;
    logic [FW-1:0]   head_dat;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    // Credit counts only registered state, so same-cycle pops/returns free nothing until next cycle.
    assign imem_req_valid = (state_q != BOOT) &&
                            (({1'b0, in_flight_q} + {1'b0, fifo_count}) < SW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign pop            = instr_valid && instr_ready;
    assign push           = imem_rsp_valid && (drop_cnt_q == '0) && !redirect && !fifo_full;
    assign target_pc      = redirect_pc & ~XLEN'(3);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        drop_cnt_d  = drop_cnt_q;
        in_flight_d = in_flight_q + CW'(accept) - CW'(imem_rsp_valid);
        if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (push)   resp_pc_d  = resp_pc_q + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
        // Everything still outstanding after this cycle belongs to the old path.
        if (redirect) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            drop_cnt_d = in_flight_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
            case (state_q)
                BOOT:    state_q <= RUN;
                default: state_q <= (drop_cnt_d != '0) ? FLUSH : RUN;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat ({resp_pc_q, imem_rsp_data}),
        .pop      (pop),
        .flush    (redirect),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign instr_valid   = !fifo_empty;
    assign instr         = fifo_empty ? INSTR_NOP : head_dat[31:0];
    assign instr_pc      = fifo_empty ? '0 : head_dat[FW-1:32];
    assign instr_pcplus4 = instr_pc + XLEN'(4);
    assign op            = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7b5      = instr[30];

endmodule
